// File: rtl/fetch_queue_pkg.sv
// Shared constants, entry layout and pointer-width helper for the fetch queue.
package fetch_queue_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int XLEN_DEF  = 64;
  localparam int ILEN_DEF  = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fq_entry_t;

  // Index bits plus one wrap bit so full and empty are distinguishable.
  function automatic int PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fq_ptr.sv
// Wrap-bit pointer register: clear wins over increment, synchronous active-low reset.
module fq_ptr #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue pairing fetched PCs with in-order ICU responses for decode.
// Optional perf counters are enabled with the FETCH_QUEUE_PERF_EN macro.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int ILEN  = ILEN_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic                      io_resp_vld,
  input  logic [ILEN-1:0]           io_resp_inst,
  input  logic                      io_flush_vld,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [ILEN-1:0]           out_inst,
  output logic [PTR_W(DEPTH)-1:0]   io_occ
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]               io_perf_full_cyc,
  output logic [31:0]               io_perf_flush_cnt
`endif
);

  localparam int PW = PTR_W(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready, and flush forces
  // both in_ready and out_valid low for its cycle.

  fq_entry_t mem [DEPTH];

  logic [PW-1:0] wptr, fptr, rptr;
  logic [PW-1:0] sq_cnt;
  logic [PW-1:0] unfilled;
  logic [PW:0]   pend, pend_m1;
  logic          full, push, fill, squash, pop;

  assign unfilled = wptr - fptr;
  assign io_occ   = wptr - rptr;
  assign full     = (io_occ == DEPTH_P);
  assign pend     = {1'b0, sq_cnt} + {1'b0, unfilled};
  assign pend_m1  = pend - (PW+1)'(1);

  // Outstanding ICU requests (live + squashed) never exceed DEPTH.
  assign in_ready  = !full && (pend < {1'b0, DEPTH_P}) && !io_flush_vld;
  assign out_valid = (fptr != rptr) && !io_flush_vld;
  assign out_pc    = mem[rptr[AW-1:0]].pc;
  assign out_inst  = mem[rptr[AW-1:0]].inst;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign squash = io_resp_vld && (sq_cnt != '0);
  assign fill   = io_resp_vld && (sq_cnt == '0) && (unfilled != '0);

  fq_ptr #(.W(PW)) u_wptr (.clock(clock), .reset(reset), .inc(push), .clear(io_flush_vld), .ptr(wptr));
  fq_ptr #(.W(PW)) u_fptr (.clock(clock), .reset(reset), .inc(fill), .clear(io_flush_vld), .ptr(fptr));
  fq_ptr #(.W(PW)) u_rptr (.clock(clock), .reset(reset), .inc(pop),  .clear(io_flush_vld), .ptr(rptr));

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]].pc   <= in_pc;
    if (fill) mem[fptr[AW-1:0]].inst <= io_resp_inst;
  end

  // On flush every still-unfilled entry becomes a response to discard; a
  // same-cycle response retires one of them whichever pool it came from.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sq_cnt <= '0;
    end else if (io_flush_vld) begin
      sq_cnt <= (io_resp_vld && pend != '0) ? pend_m1[PW-1:0] : pend[PW-1:0];
    end else if (squash) begin
      sq_cnt <= sq_cnt - PW'(1);
    end
  end

  resp_has_target: assert property (@(posedge clock) disable iff (!reset)
    !(io_resp_vld && sq_cnt == '0 && unfilled == '0));

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      io_perf_full_cyc  <= '0;
      io_perf_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && !io_flush_vld && io_perf_full_cyc != '1)
        io_perf_full_cyc <= io_perf_full_cyc + 32'd1;
      if (io_flush_vld && io_perf_flush_cnt != '1)
        io_perf_flush_cnt <= io_perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, full/wrap, flush squashing,
// outstanding-request bound and mid-operation reset.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_pc;
  logic        io_resp_vld;
  logic [31:0] io_resp_inst;
  logic        io_flush_vld;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  io_occ;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] io_perf_full_cyc, io_perf_flush_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fetch_queue dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .io_resp_vld(io_resp_vld), .io_resp_inst(io_resp_inst),
    .io_flush_vld(io_flush_vld),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .io_occ(io_occ)
`ifdef FETCH_QUEUE_PERF_EN
    , .io_perf_full_cyc(io_perf_full_cyc), .io_perf_flush_cnt(io_perf_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of inputs, then let combinational outputs settle.
  task automatic drv(input logic iv, input logic [63:0] pc, input logic rv,
                     input logic [31:0] inst, input logic fl, input logic ordy);
    in_valid     = iv;
    in_pc        = pc;
    io_resp_vld  = rv;
    io_resp_inst = inst;
    io_flush_vld = fl;
    out_ready    = ordy;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, 64'(out_inst), 64'(inst));
  endtask

  initial begin
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occ", 64'(io_occ), 64'd0);

    // Stream: responses one cycle behind pushes, decode always ready.
    drv(1, 64'h1000, 0, 0, 0, 1);
    check("s_out_t0", 64'(out_valid), 64'd0);
    tick();
    drv(1, 64'h1004, 1, 32'hA000_0000, 0, 1);
    check("s_out_t1", 64'(out_valid), 64'd0);
    tick();
    drv(1, 64'h1008, 1, 32'hA000_0001, 0, 1);
    expect_out("s_o0", 64'h1000, 32'hA000_0000);
    tick();
    drv(0, 0, 1, 32'hA000_0002, 0, 1);
    expect_out("s_o1", 64'h1004, 32'hA000_0001);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    expect_out("s_o2", 64'h1008, 32'hA000_0002);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    check("s_empty", 64'(out_valid), 64'd0);
    check("s_occ", 64'(io_occ), 64'd0);

    // Full: eight pushes with trailing fills, decode stalled.
    for (int i = 0; i < 8; i++) begin
      drv(1, 64'h3000 + 64'(4*i), (i > 0), 32'hC0DE_0000 + 32'(i-1), 0, 0);
      tick();
    end
    drv(0, 0, 1, 32'hC0DE_0007, 0, 0);
    tick();
    drv(1, 64'h4000, 0, 0, 0, 0);
    check("f_in_ready", 64'(in_ready), 64'd0);
    check("f_occ", 64'(io_occ), 64'd8);
    expect_out("f_head", 64'h3000, 32'hC0DE_0000);
    tick();
    drv(1, 64'h4000, 0, 0, 0, 1);
    check("f_pop_ready", 64'(in_ready), 64'd0);
    tick();
    drv(1, 64'h4000, 0, 0, 0, 0);
    check("f_after_pop_ready", 64'(in_ready), 64'd1);
    check("f_after_pop_occ", 64'(io_occ), 64'd7);
    tick();
    drv(0, 0, 1, 32'hC0DE_0009, 0, 0);
    check("f_occ9", 64'(io_occ), 64'd8);
    tick();
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 0, 0, 0, 1);
      if (k < 7) expect_out("f_drain", 64'h3004 + 64'(4*k), 32'hC0DE_0001 + 32'(k));
      else       expect_out("f_wrap", 64'h4000, 32'hC0DE_0009);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    check("f_drained", 64'(io_occ), 64'd0);

    // Flush with three unfilled entries outstanding.
    for (int i = 0; i < 4; i++) begin
      drv(1, 64'h5000 + 64'(4*i), 0, 0, 0, 0);
      tick();
    end
    drv(0, 0, 1, 32'hB000_0000, 0, 0);
    tick();
    drv(1, 64'h5010, 0, 0, 1, 1);
    check("fl_in_ready", 64'(in_ready), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    tick();
    drv(1, 64'h2000, 1, 32'hDEAD_0001, 0, 1);
    check("fl_occ", 64'(io_occ), 64'd0);
    check("fl_sq", 64'(dut.sq_cnt), 64'd3);
    tick();
    drv(0, 0, 1, 32'hDEAD_0002, 0, 1);
    check("fl_drop1", 64'(out_valid), 64'd0);
    tick();
    drv(0, 0, 1, 32'hDEAD_0003, 0, 1);
    check("fl_drop2", 64'(out_valid), 64'd0);
    tick();
    drv(0, 0, 1, 32'h2000_1111, 0, 1);
    check("fl_drop3", 64'(out_valid), 64'd0);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    expect_out("fl_new", 64'h2000, 32'h2000_1111);
    check("fl_sq0", 64'(dut.sq_cnt), 64'd0);
    tick();

    // Flush coincident with a response and decode ready.
    drv(1, 64'h6000, 0, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 1, 1);
    tick();
    drv(1, 64'h6100, 0, 0, 0, 1);
    check("co_sq1", 64'(dut.sq_cnt), 64'd1);
    tick();
    drv(1, 64'h6104, 0, 0, 0, 1);
    tick();
    drv(1, 64'h6108, 1, 32'hEEEE_0000, 1, 1);
    check("co_in_ready", 64'(in_ready), 64'd0);
    check("co_out_valid", 64'(out_valid), 64'd0);
    tick();
    drv(0, 0, 1, 32'hEEEE_0001, 0, 1);
    check("co_sq2", 64'(dut.sq_cnt), 64'd2);
    check("co_occ", 64'(io_occ), 64'd0);
    tick();
    drv(0, 0, 1, 32'hEEEE_0002, 0, 1);
    check("co_sq_dec", 64'(dut.sq_cnt), 64'd1);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    check("co_sq_end", 64'(dut.sq_cnt), 64'd0);
    check("co_empty", 64'(out_valid), 64'd0);

    // Outstanding bound: six squashed requests plus two live ones saturate.
    for (int i = 0; i < 6; i++) begin
      drv(1, 64'h7000 + 64'(4*i), 0, 0, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0, 1, 0);
    tick();
    drv(1, 64'h8000, 0, 0, 0, 0);
    check("ob_sq6", 64'(dut.sq_cnt), 64'd6);
    check("ob_rdy0", 64'(in_ready), 64'd1);
    tick();
    drv(1, 64'h8004, 0, 0, 0, 0);
    check("ob_rdy1", 64'(in_ready), 64'd1);
    tick();
    drv(1, 64'h8008, 0, 0, 0, 0);
    check("ob_block", 64'(in_ready), 64'd0);
    tick();
    drv(1, 64'h8008, 1, 32'h0, 0, 0);
    check("ob_block_resp", 64'(in_ready), 64'd0);
    tick();
    drv(0, 0, 1, 32'h0, 0, 0);
    check("ob_release", 64'(in_ready), 64'd1);
    tick();
    drv(0, 0, 1, 32'h0, 0, 0);
    tick();
    drv(0, 0, 1, 32'h0, 0, 0);
    tick();
    drv(1, 64'h8008, 0, 0, 0, 0);
    tick();
    drv(1, 64'h800C, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    check("mr_pre_sq", 64'(dut.sq_cnt), 64'd2);
    check("mr_pre_occ", 64'(io_occ), 64'd4);
`ifdef FETCH_QUEUE_PERF_EN
    check("mr_pre_full_cyc", 64'(io_perf_full_cyc), 64'd4);
    check("mr_pre_flush_cnt", 64'(io_perf_flush_cnt), 64'd4);
`endif

    // Mid-operation reset for a single edge.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_occ", 64'(io_occ), 64'd0);
    check("mr_sq", 64'(dut.sq_cnt), 64'd0);
`ifdef FETCH_QUEUE_PERF_EN
    check("mr_full_cyc", 64'(io_perf_full_cyc), 64'd0);
    check("mr_flush_cnt", 64'(io_perf_flush_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling queue directly downstream of the 2-stage fetch unit.
- Accepts each fetched PC from the fetch out handshake and allocates an entry for it.
- Pairs each entry, in order, with the instruction word returned by the ICU response path.
- Presents completed PC+instruction pairs to decode over a valid/ready handshake.
- Redirect flushes the queue and squashes ICU responses still in flight.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2, ≥2.
- XLEN, 64, PC width.
- ILEN, 32, instruction word width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  fetch offers a PC.
- in_ready  out  1  queue can allocate an entry.
- in_pc  in  XLEN  fetched PC.
- io_resp_vld  in  1  ICU returns one instruction word (in request order).
- io_resp_inst  in  ILEN  instruction word.
- io_flush_vld  in  1  redirect (restart or branch); kills all queue contents.
- out_valid  out  1  head entry complete.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  head PC.
- out_inst  out  ILEN  head instruction.
- io_occ  out  clog2(DEPTH)+1  allocated entries (wptr−rptr).

Behaviour:
- State:
  - Entry array of {pc, inst}.
  - Three pointers, each clog2(DEPTH)+1 bits with a wrap bit: wptr (allocate), fptr (fill), rptr (read). Invariant rptr ≤ fptr ≤ wptr, in modular order.
  - sq_cnt (clog2(DEPTH)+1 bits): number of ICU responses to discard.
- Reset (reset==0 at a clock edge): wptr=fptr=rptr=0, sq_cnt=0. Outputs then read in_ready=1, out_valid=0, io_occ=0. Entry contents are don't-care.
- Derived values:
  - unfilled = wptr−fptr.
  - full = (wptr−rptr)==DEPTH.
- in_ready = !full && (sq_cnt+unfilled) < DEPTH && !io_flush_vld. This bounds the ICU's outstanding requests to DEPTH.
- Push: when in_valid && in_ready, write in_pc at wptr and increment wptr.
- Fill: io_resp_vld with sq_cnt==0 writes io_resp_inst at fptr and increments fptr.
  - A fill only targets entries allocated in earlier cycles.
  - Response with sq_cnt==0 and unfilled==0 is a protocol error; the design ignores it and an assertion fires.
- Squash: io_resp_vld with sq_cnt>0 decrements sq_cnt; the data is dropped.
- out_valid = (fptr!=rptr) && !io_flush_vld. out_pc and out_inst come from entry[rptr].
- Pop: when out_valid && out_ready, increment rptr.
- Latency:
  - Push at cycle N; response at ≥N+1; out_valid at the cycle after the fill.
  - Minimum push→out is 2 cycles. No bypass.
- Flush (io_flush_vld=1):
  - Next state: wptr=fptr=rptr=0.
  - sq_cnt_next = sq_cnt + unfilled − (io_resp_vld ? 1 : 0).
  - The same-cycle response counts against whichever of sq_cnt or unfilled it would have consumed.
  - Flush beats a same-cycle push (in_ready=0) and a same-cycle pop (out_valid=0).
- Simultaneous push, fill and pop in one cycle are all legal. io_occ updates by +push−pop.
- Wrap-around: pointers wrap naturally; the wrap bit distinguishes full from empty.
- Reset has priority over flush and all handshakes.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: adds two outputs, both reset to 0 and saturating at all-ones:
  - io_perf_full_cyc (32): increments each cycle in_valid && !in_ready && !io_flush_vld.
  - io_perf_flush_cnt (32): increments on each io_flush_vld cycle.
- Undefined: ports and counters are absent; core behaviour is unchanged.

Decomposition:
- Package fetch_queue_pkg holds:
  - the default constants for DEPTH, XLEN and ILEN;
  - the fq_entry_t struct {pc, inst};
  - the pointer width function PTR_W(DEPTH) = clog2(DEPTH)+1.
- One sub-module is natural: fq_ptr, a wrap-bit pointer register with inc and clear inputs and synchronous active-low reset. It is instantiated three times for wptr, fptr and rptr.

Test Plan:
- Reset then stream: push PCs 0x1000,0x1004,0x1008 on consecutive cycles, responses one cycle after each push, out_ready=1 → out emits (0x1000,I0),(0x1004,I1),(0x1008,I2) starting 2 cycles after the first push, in order.
- Full: out_ready=0, push 8 PCs, fill all → in_ready=0, io_occ=8. Pop one → in_ready=1 next cycle, and the 9th push lands in the wrapped slot 0.
- Flush with outstanding: push 4, fill 1, then flush → out_valid=0, io_occ=0, sq_cnt=3. The next 3 responses are dropped; a new PC 0x2000 plus a 4th response → out (0x2000, that inst).
- Flush coincident with response and pop: 2 unfilled, sq_cnt=1, io_resp_vld=1, out_ready=1 during flush → sq_cnt=2, no pop, pointers 0.
- Outstanding bound: sq_cnt=6 after flush, push 2 → in_ready=0 until a response decrements sq_cnt.
- Mid-operation reset: queue half full with sq_cnt=2, assert reset=0 for one edge → in_ready=1, out_valid=0, io_occ=0; with FETCH_QUEUE_PERF_EN both perf counters read 0.
